weight_loader: RTL and testbench

Read-side sequencer for the double-buffered weight buffer. On a start pulse it drains ROWS×COLS weight bytes from the buffer's read FIFO, packs each group of COLS bytes into one row word, and shifts rows into the systolic array's weight registers. After the last row it issues a latch strobe so the array commits the new weight set. It sits between the weight buffer's read port and the array's weight-load inputs.

---
 rtl/weight_loader.sv | 123 ++++++++++++
 tb/tb_weight_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// weight_loader: pops ROWS*COLS weight bytes, packs them into rows, shifts each row into the array, then latches.
// Latency: start -> first pop next cycle (+1 with WEIGHT_LOADER_AUTO_SWAP_EN); done at cycle ROWS*(COLS+1)+1 (+1) with no stalls.
// Backpressure: buf_empty stalls FILL one cycle per empty cycle; start is ignored while busy.
module weight_loader #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       buf_rd_en,
    input  logic [DATA_WIDTH-1:0]      buf_data,
    input  logic                       buf_empty,
    output logic                       buf_swap,
    output logic [DATA_WIDTH*COLS-1:0] w_data,
    output logic                       w_shift,
    output logic                       w_latch
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SWAP  = 3'd1,
        S_FILL  = 3'd2,
        S_SHIFT = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [RW-1:0]                row_cnt_q, row_cnt_d;
    logic [CW-1:0]                col_cnt_q, col_cnt_d;
    logic [DATA_WIDTH*COLS-1:0]   w_data_q, w_data_d;

    // State, counters and the row assembly register; reset aborts any load in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            w_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            w_data_q  <= w_data_d;
        end
    end

    // Next-state logic and strobes; pops are combinational so the FWFT head is consumed the same cycle.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        w_data_d  = w_data_q;
        buf_rd_en = 1'b0;
        buf_swap  = 1'b0;
        w_shift   = 1'b0;
        w_latch   = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                    w_data_d  = '0;
`ifdef WEIGHT_LOADER_AUTO_SWAP_EN
                    state_d   = S_SWAP;
`else
                    state_d   = S_FILL;
`endif
                end
            end
`ifdef WEIGHT_LOADER_AUTO_SWAP_EN
            S_SWAP: begin
                // Flip the double buffer so the freshly written half becomes readable.
                buf_swap = 1'b1;
                state_d  = S_FILL;
            end
`endif
            S_FILL: begin
                if (!buf_empty) begin
                    buf_rd_en = 1'b1;
                    w_data_d[int'(col_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = buf_data;
                    if (col_cnt_q == COL_LAST) begin
                        col_cnt_d = '0;
                        state_d   = S_SHIFT;
                    end else begin
                        col_cnt_d = col_cnt_q + CW'(1);
                    end
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (row_cnt_q == ROW_LAST) begin
                    state_d = S_LATCH;
                end else begin
                    row_cnt_d = row_cnt_q + RW'(1);
                    state_d   = S_FILL;
                end
            end
            S_LATCH: begin
                w_latch = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_data = w_data_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed cycle-by-cycle bench for weight_loader (4x4, 8-bit).
// Latency: expected shift/done cycles are hand-written per load; the macro adds one cycle.
// Backpressure: stalls are driven on buf_empty; a simple FWFT byte source feeds buf_data.
module tb_weight_loader;

`ifdef WEIGHT_LOADER_AUTO_SWAP_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        buf_rd_en;
    logic [7:0]  buf_data;
    logic        buf_empty;
    logic        buf_swap;
    logic [31:0] w_data;
    logic        w_shift;
    logic        w_latch;

    logic [7:0]  mem [0:255];
    int          ptr = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_row = '0;

    always #5 clk = ~clk;

    assign buf_data = mem[ptr[7:0]];

    weight_loader #(.ROWS(4), .COLS(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .buf_rd_en (buf_rd_en),
        .buf_data  (buf_data),
        .buf_empty (buf_empty),
        .buf_swap  (buf_swap),
        .w_data    (w_data),
        .w_shift   (w_shift),
        .w_latch   (w_latch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"},    {31'd0, busy},      32'd0);
        check({tag, " done"},    {31'd0, done},      32'd0);
        check({tag, " rd_en"},   {31'd0, buf_rd_en}, 32'd0);
        check({tag, " swap"},    {31'd0, buf_swap},  32'd0);
        check({tag, " shift"},   {31'd0, w_shift},   32'd0);
        check({tag, " latch"},   {31'd0, w_latch},   32'd0);
        check({tag, " w_data"},  w_data,             32'd0);
    endtask

    // One load starting with start=1 in cycle 0. Cycle numbers are given for the build
    // without the swap state; OFF shifts DUT-driven events. abort_c>=0 pulses rst in that cycle.
    task automatic run_load(input string tag,
                            input int sh0, input int sh1, input int sh2, input int sh3,
                            input int done_c, input int st_a, input int st_b,
                            input int emp_lo, input int emp_hi, input int abort_c);
        int          shc [4];
        logic [31:0] row_exp [4];
        int          p0;
        int          last;
        int          dc;
        logic        is_sh;
        int          kk;
        logic        exp_busy, exp_done, exp_swap, exp_fill, exp_rd, pop;
        int          idx;

        shc = '{sh0 + OFF, sh1 + OFF, sh2 + OFF, sh3 + OFF};
        dc  = done_c + OFF;
        p0  = ptr;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                idx = p0 + 4 * r + c;
                row_exp[r][c*8 +: 8] = mem[idx[7:0]];
            end
        end
        last = (abort_c >= 0) ? abort_c : dc;

        for (int cyc = 0; cyc <= last; cyc++) begin
            start     = (cyc == 0) || (cyc == st_a) || (cyc == st_b);
            buf_empty = (cyc >= emp_lo + OFF) && (cyc <= emp_hi + OFF);
            if (cyc == abort_c) rst = 1'b1;
            @(negedge clk);
            if (cyc == abort_c) begin
                check_quiet({tag, " abort"});
                last_row = '0;
            end else begin
                is_sh = 1'b0;
                kk    = 0;
                for (int k = 0; k < 4; k++) begin
                    if (shc[k] == cyc) begin
                        is_sh = 1'b1;
                        kk    = k;
                    end
                end
                exp_busy = (cyc >= 1) && (cyc <= dc);
                exp_done = (cyc == dc);
                exp_swap = (OFF == 1) && (cyc == 1);
                exp_fill = exp_busy && !is_sh && !exp_done && !exp_swap;
                exp_rd   = exp_fill && !buf_empty;
                check({tag, " busy"},  {31'd0, busy},      {31'd0, exp_busy});
                check({tag, " done"},  {31'd0, done},      {31'd0, exp_done});
                check({tag, " latch"}, {31'd0, w_latch},   {31'd0, exp_done});
                check({tag, " swap"},  {31'd0, buf_swap},  {31'd0, exp_swap});
                check({tag, " shift"}, {31'd0, w_shift},   {31'd0, is_sh});
                check({tag, " rd_en"}, {31'd0, buf_rd_en}, {31'd0, exp_rd});
                if (cyc == 0) check({tag, " idle hold w_data"}, w_data, last_row);
                if (is_sh) begin
                    check({tag, " row w_data"}, w_data, row_exp[kk]);
                    last_row = row_exp[kk];
                end
            end
            pop = buf_rd_en;
            @(posedge clk);
            #1;
            if (pop) ptr++;
        end
        start     = 1'b0;
        buf_empty = 1'b0;
        rst       = 1'b0;
        if (abort_c < 0) check({tag, " pop count"}, ptr - p0, 32'd16);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);

        // Reset held with start high and data available: nothing moves.
        rst       = 1'b1;
        start     = 1'b1;
        buf_empty = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_quiet("reset");
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_quiet("post-reset");
            @(posedge clk);
            #1;
        end
        check("no pops in reset", ptr, 32'd0);

        // Full rate, bytes 0x01..0x10.
        run_load("full", 5, 10, 15, 20, 21, -1, -1, -1, -2, -1);
        check("first load row3", last_row, 32'h100F0E0D);
        // Three empty cycles in row 1.
        run_load("stall", 5, 13, 18, 23, 24, -1, -1, 7, 9, -1);
        // Extra starts during the load are ignored; next call is back-to-back.
        run_load("ign_start", 5, 10, 15, 20, 21, 3, 12, -1, -2, -1);
        run_load("b2b", 5, 10, 15, 20, 21, -1, -1, -1, -2, -1);
        // Reset in cycle 7 aborts, then a fresh load.
        run_load("abort", 5, 10, 15, 20, 21, -1, -1, -1, -2, 7);
        run_load("after_abort", 5, 10, 15, 20, 21, -1, -1, -1, -2, -1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("tail busy", {31'd0, busy}, 32'd0);
            check("tail done", {31'd0, done}, 32'd0);
            check("tail swap", {31'd0, buf_swap}, 32'd0);
            check("tail rd_en", {31'd0, buf_rd_en}, 32'd0);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
